uart_tx_scheduler: RTL and testbench

Shares the single UART transmitter among three requesters: ACK packets, configuration packets and payload bytes from the TX FIFO. It sequences each packet byte by byte through a start/done handshake with the transmitter. It sits inside the main controller, between the TX FIFO, the configuration-handshake logic and the transmitter.

---
 rtl/uart_tx_scheduler.sv | 142 ++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - shares one UART transmitter among ACK, config and FIFO payload packets
// Optional: define UART_TX_HOLDOFF_EN to hold off new grants while the receiver is mid-frame.
module uart_tx_scheduler #(
  parameter logic [7:0] SYN_ID       = 8'hD2,
  parameter logic [7:0] ACK_ID       = 8'hA1,
  parameter int         DONE_TIMEOUT = 4096
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       tx_en_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_data_i,
  output logic       fifo_read_o,
  input  logic       cfg_req_i,
  input  logic [7:0] cfg_data_i,
  output logic       cfg_done_o,
  input  logic       ack_req_i,
  output logic       ack_done_o,
  output logic       tx_start_o,
  output logic [7:0] tx_data_o,
  input  logic       tx_done_i,
  input  logic       is_receiving_i,
  output logic       busy_o,
  output logic       timeout_o
);
  localparam int               CNT_W    = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DONE_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, START, WAIT_DONE} state_t;
  typedef enum logic [1:0] {PKT_DATA, PKT_ACK, PKT_CFG} pkt_t;

  state_t           state_q, state_d;
  pkt_t             pkt_q, pkt_d;
  logic             more_q, more_d;
  logic [7:0]       cfg_q, cfg_d;
  logic [7:0]       byte_q, byte_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ack_done_d, cfg_done_d;
  logic             grant_ok, ack_pend, cfg_pend;

`ifdef UART_TX_HOLDOFF_EN
  assign grant_ok = !is_receiving_i;
`else
  logic unused_is_receiving;
  assign unused_is_receiving = is_receiving_i;
  assign grant_ok = 1'b1;
`endif

  // A requester still sees its level high in the cycle its done pulses; don't regrant it then.
  assign ack_pend = ack_req_i && !ack_done_o;
  assign cfg_pend = cfg_req_i && !cfg_done_o;

  always_comb begin
    state_d     = state_q;
    pkt_d       = pkt_q;
    more_d      = more_q;
    cfg_d       = cfg_q;
    byte_d      = byte_q;
    cnt_d       = cnt_q;
    fifo_read_o = 1'b0;
    timeout_o   = 1'b0;
    ack_done_d  = 1'b0;
    cfg_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_ok) begin
          if (ack_pend) begin
            pkt_d   = PKT_ACK;
            more_d  = 1'b0;
            byte_d  = ACK_ID;
            state_d = START;
          end else if (cfg_pend) begin
            pkt_d   = PKT_CFG;
            more_d  = 1'b1;
            cfg_d   = cfg_data_i;
            byte_d  = SYN_ID;
            state_d = START;
          end else if (tx_en_i && !fifo_empty_i) begin
            fifo_read_o = 1'b1;
            pkt_d       = PKT_DATA;
            more_d      = 1'b0;
            state_d     = FETCH;
          end
        end
      end
      FETCH: begin
        byte_d  = fifo_data_i;
        state_d = START;
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT_DONE;
      end
      WAIT_DONE: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (tx_done_i) begin
          if (more_q) begin
            more_d  = 1'b0;
            byte_d  = cfg_q;
            state_d = START;
          end else begin
            ack_done_d = (pkt_q == PKT_ACK);
            cfg_done_d = (pkt_q == PKT_CFG);
            state_d    = IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          // Abandon the rest of the packet; the requester is still pending and gets re-arbitrated.
          timeout_o = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      pkt_q      <= PKT_DATA;
      more_q     <= 1'b0;
      cfg_q      <= 8'h00;
      byte_q     <= 8'h00;
      cnt_q      <= '0;
      ack_done_o <= 1'b0;
      cfg_done_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      more_q     <= more_d;
      cfg_q      <= cfg_d;
      byte_q     <= byte_d;
      cnt_q      <= cnt_d;
      ack_done_o <= ack_done_d;
      cfg_done_o <= cfg_done_d;
    end
  end

  assign tx_data_o  = byte_q;
  assign tx_start_o = (state_q == START);
  assign busy_o     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - randomized and directed self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
  localparam int TO   = 8;
  localparam int MAXC = 16384;

  logic       clk = 1'b0, rst_i = 1'b1;
  logic       tx_en_i = 1'b0, fifo_empty_i = 1'b1, cfg_req_i = 1'b0, ack_req_i = 1'b0;
  logic       tx_done_i = 1'b0, is_receiving_i = 1'b0;
  logic [7:0] fifo_data_i = 8'h00, cfg_data_i = 8'h00;
  logic       fifo_read_o, cfg_done_o, ack_done_o, tx_start_o, busy_o, timeout_o;
  logic [7:0] tx_data_o;

  uart_tx_scheduler #(.SYN_ID(8'hD2), .ACK_ID(8'hA1), .DONE_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .tx_en_i(tx_en_i), .fifo_empty_i(fifo_empty_i),
    .fifo_data_i(fifo_data_i), .fifo_read_o(fifo_read_o), .cfg_req_i(cfg_req_i),
    .cfg_data_i(cfg_data_i), .cfg_done_o(cfg_done_o), .ack_req_i(ack_req_i),
    .ack_done_o(ack_done_o), .tx_start_o(tx_start_o), .tx_data_o(tx_data_o),
    .tx_done_i(tx_done_i), .is_receiving_i(is_receiving_i), .busy_o(busy_o),
    .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: requesters, FIFO, transmitter and a per-cycle record of who was pending.
  bit         ack_p_h[MAXC], cfg_p_h[MAXC], rd_h[MAXC];
  logic [7:0] cfgb_h[MAXC];
  logic [7:0] fifo_q[$], data_pend[$], exp_q[$], sent[$];
  int         done_log[$];
  bit         ack_req = 0, ack_want = 0, cfg_req = 0, cfg_want = 0, cfg_granted = 0;
  bit         tx_en = 0, recv = 0, done_n = 0, rand_dly = 0, in_flight = 0, s_busy = 0;
  bit         dexp_ack = 0, dexp_cfg = 0, busy_after = 1;
  logic [7:0] cfg_byte = 8'h00, cfg_want_byte = 8'h00, fdata_n = 8'h00;
  int         t_left = 0, dly = 2, kind = 0, start_cyc = 0, dexp_cyc = 0, txd_cyc = -10;
  int         n_ack_done = 0, n_cfg_done = 0, n_to = 0, n_start = 0;
  int         last_rd_cyc = -1, last_start_cyc = -1;

  function automatic bit idle_now();
    return !ack_req && !ack_want && !cfg_req && !cfg_want && fifo_q.size() == 0 &&
           data_pend.size() == 0 && !in_flight && !dexp_ack && !dexp_cfg && !s_busy && t_left == 0;
  endfunction

  task automatic model_reset();
    in_flight = 0; exp_q.delete(); data_pend.delete(); t_left = 0; done_n = 0;
    dexp_ack = 0; dexp_cfg = 0; cfg_granted = 0;
  endtask

  task automatic cycle();
    bit ap, cp, exp_to;
    logic [7:0] b;
    ack_req_i      = ack_req;
    cfg_req_i      = cfg_req;
    cfg_data_i     = (cfg_req && cfg_granted) ? 8'($urandom) : cfg_byte;
    fifo_empty_i   = (fifo_q.size() == 0);
    fifo_data_i    = fdata_n;
    tx_done_i      = done_n;
    tx_en_i        = tx_en;
    is_receiving_i = recv;
    #1;
    ap = ack_req_i && !ack_done_o;
    cp = cfg_req_i && !cfg_done_o;
`ifdef UART_TX_HOLDOFF_EN
    if (is_receiving_i) begin ap = 0; cp = 0; end
`endif
    ack_p_h[cyc] = ap; cfg_p_h[cyc] = cp; cfgb_h[cyc] = cfg_data_i; rd_h[cyc] = fifo_read_o;
    s_busy = busy_o;
    if (cyc == txd_cyc + 1) busy_after = busy_o;

    fdata_n = 8'($urandom);
    if (fifo_read_o) begin
      last_rd_cyc = cyc;
      check("rd_cond", {27'd0, tx_en_i, fifo_q.size() != 0, ap, cp, is_receiving_i}, 32'b11000);
      if (fifo_q.size() != 0) begin
        fdata_n = fifo_q.pop_front();
        data_pend.push_back(fdata_n);
      end
    end

    if (tx_done_i && in_flight) begin
      in_flight = 0;
      txd_cyc = cyc;
      if (exp_q.size() == 0) begin
        dexp_ack = (kind == 1); dexp_cfg = (kind == 2); dexp_cyc = cyc;
      end
    end

    if (in_flight) begin
      check("busy", 32'(busy_o), 1);
      exp_to = (cyc - start_cyc == TO);
      if (timeout_o || exp_to) check("timeout", 32'(timeout_o), 32'(exp_to));
      if (timeout_o) begin
        n_to++; in_flight = 0; exp_q.delete(); t_left = 0; cfg_granted = 0;
      end
    end else if (timeout_o) check("timeout_idle", 32'(timeout_o), 0);

    if (ack_done_o) begin
      check("ack_done", 32'(dexp_ack), 1);
      dexp_ack = 0; n_ack_done++; done_log.push_back(1);
    end
    if (cfg_done_o) begin
      check("cfg_done", 32'(dexp_cfg), 1);
      dexp_cfg = 0; n_cfg_done++; done_log.push_back(2);
    end
    if ((dexp_ack || dexp_cfg) && cyc > dexp_cyc) begin
      check("done_pulse", {30'd0, dexp_ack, dexp_cfg}, 0);
      dexp_ack = 0; dexp_cfg = 0;
    end

    if (tx_start_o) begin
      b = tx_data_o; n_start++; sent.push_back(b); last_start_cyc = cyc;
      check("start_overlap", 32'(in_flight), 0);
      if (exp_q.size() != 0) check("cfg_byte", 32'(b), 32'(exp_q.pop_front()));
      else if (cyc >= 2 && rd_h[cyc-2]) begin
        kind = 0;
        if (data_pend.size() != 0) check("data_byte", 32'(b), 32'(data_pend.pop_front()));
        else check("data_pend", 32'(data_pend.size()), 1);
      end else if (cyc >= 1 && ack_p_h[cyc-1]) begin
        kind = 1; check("ack_byte", 32'(b), 32'hA1);
      end else if (cyc >= 1 && cfg_p_h[cyc-1]) begin
        kind = 2; check("syn_byte", 32'(b), 32'hD2);
        exp_q.push_back(cfgb_h[cyc-1]); cfg_granted = 1;
      end else check("start_src", 32'(tx_start_o), 0);
      in_flight = 1; start_cyc = cyc;
      t_left = rand_dly ? int'($urandom_range(TO, 1)) : dly;
    end

    done_n = 0;
    if (t_left > 0) begin done_n = (t_left == 1); t_left--; end

    if (ack_done_o) ack_req = 0;
    else if (!ack_req && ack_want) begin ack_req = 1; ack_want = 0; end
    if (cfg_done_o) begin cfg_req = 0; cfg_granted = 0; end
    else if (!cfg_req && cfg_want) begin cfg_req = 1; cfg_byte = cfg_want_byte; cfg_want = 0; end

    @(negedge clk);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget got=%0d exp<%0d", cyc, MAXC);
      $fatal(1);
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    bit ok;
    do begin cycle(); n++; ok = idle_now(); end while (!ok && n < bound);
    check("idle_wait", 32'(ok), 1);
  endtask

  initial begin
    int n0, s0, d0, d1, to0, c0;
    repeat (3) @(negedge clk);
    #1 check("rst_outs", 32'({fifo_read_o, cfg_done_o, ack_done_o, tx_start_o, tx_data_o, busy_o, timeout_o}), 0);
    @(negedge clk);
    rst_i = 0;

    // Single FIFO byte: read at cycle 0, start at cycle 2, idle the cycle after tx_done.
    n0 = sent.size(); c0 = cyc;
    tx_en = 1; fifo_q.push_back(8'h55);
    wait_idle(30);
    check("t1_rd_lat", 32'(last_rd_cyc - c0), 0);
    check("t1_start_lat", 32'(last_start_cyc - c0), 2);
    check("t1_byte", 32'(sent[n0]), 32'h55);
    check("t1_busy_after", 32'(busy_after), 0);

    // Config packet: SYN then config byte, one cfg_done.
    n0 = sent.size(); d0 = n_cfg_done;
    cfg_req = 1; cfg_byte = 8'h3C;
    wait_idle(60);
    check("t2_syn", 32'(sent[n0]), 32'hD2);
    check("t2_cfg", 32'(sent[n0+1]), 32'h3C);
    check("t2_len", 32'(sent.size() - n0), 2);
    check("t2_done", 32'(n_cfg_done - d0), 1);

    // ACK raised while SYN is in flight waits for the config packet to finish.
    n0 = sent.size(); s0 = n_start; dly = 4;
    cfg_req = 1; cfg_byte = 8'h3C;
    for (int i = 0; i < 10 && n_start == s0; i++) cycle();
    ack_req = 1;
    wait_idle(80);
    check("t3_order", {8'h00, sent[n0], sent[n0+1], sent[n0+2]}, 32'h00D23CA1);
    check("t3_done_order", 32'(done_log[done_log.size()-2] * 16 + done_log[done_log.size()-1]), 32'h21);

    // All three requesters in the same cycle.
    n0 = sent.size(); dly = 1;
    ack_req = 1; cfg_req = 1; cfg_byte = 8'h5A; fifo_q.push_back(8'h77);
    wait_idle(80);
    check("t4_order", {sent[n0], sent[n0+1], sent[n0+2], sent[n0+3]}, 32'hA1D25A77);

    // Timeout on SYN, then retry with tx_done exactly in the expiring cycle.
    n0 = sent.size(); to0 = n_to; d0 = n_cfg_done; dly = 0;
    cfg_req = 1; cfg_byte = 8'h3C;
    for (int i = 0; i < 30 && n_to == to0; i++) cycle();
    check("t5_to", 32'(n_to - to0), 1);
    check("t5_nodone", 32'(n_cfg_done - d0), 0);
    dly = TO;
    wait_idle(80);
    check("t5_seq", {8'h00, sent[n0], sent[n0+1], sent[n0+2]}, 32'h00D2D23C);
    check("t5_edge_noto", 32'(n_to - to0), 1);

    // Reset mid WAIT_DONE clears every output at once; the held ACK is granted again afterwards.
    s0 = n_start; dly = 0;
    ack_req = 1;
    for (int i = 0; i < 10 && n_start == s0; i++) cycle();
    repeat (3) cycle();
    rst_i = 1;
    #1 check("t6_rst_outs", 32'({fifo_read_o, cfg_done_o, ack_done_o, tx_start_o, tx_data_o, busy_o, timeout_o}), 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_i = 0; dly = 2; d1 = n_ack_done;
    wait_idle(40);
    check("t6_regrant", 32'(n_ack_done - d1), 1);
    check("t6_byte", 32'(sent[sent.size()-1]), 32'hA1);

`ifdef UART_TX_HOLDOFF_EN
    s0 = n_start;
    recv = 1; ack_req = 1;
    repeat (6) cycle();
    check("t7_block", 32'(n_start - s0), 0);
    recv = 0;
    wait_idle(30);
    check("t7_sent", 32'(n_start - s0), 1);
`endif

    // Random traffic; the transmitter always answers within the timeout window.
    to0 = n_to; rand_dly = 1;
    for (int i = 0; i < 3000; i++) begin
      if (!ack_req && !ack_want && $urandom_range(99) < 4) ack_want = 1;
      if (!cfg_req && !cfg_want && $urandom_range(99) < 4) begin
        cfg_want = 1; cfg_want_byte = 8'($urandom);
      end
      if (fifo_q.size() < 16 && $urandom_range(99) < 12) fifo_q.push_back(8'($urandom));
      if ($urandom_range(99) < 3) tx_en = !tx_en;
      cycle();
    end
    tx_en = 1;
    wait_idle(2000);
    check("rand_drained", 32'(fifo_q.size()), 0);
    check("rand_no_to", 32'(n_to - to0), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
